// File: rtl/vc_link_tx.sv
// Transmit side of a router output link: round-robin drain of NUM_VC FWFT buffers
// onto a registered link with per-VC downstream credit tracking.
// Optional packet-level VC lock is built when VC_LINK_TX_PKT_LOCK_EN is defined.
module vc_link_tx #(
    parameter  int VC_BITS = 2,
    parameter  int FLIT_W  = 32,
    parameter  int CREDITS = 32,
    parameter  int CRED_W  = 6,
    localparam int NUM_VC  = 1 << VC_BITS
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_VC*FLIT_W-1:0]   vc_data,
    output logic [NUM_VC-1:0]          vc_read_en,
    input  logic                       credit_valid,
    input  logic [VC_BITS-1:0]         credit_vc,
    output logic                       link_valid,
    output logic [VC_BITS-1:0]         link_vc,
    output logic [FLIT_W-1:0]          link_flit,
    output logic                       credit_err
);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    logic [VC_BITS-1:0] r_rr_ptr;
    logic               r_link_valid;
    logic [VC_BITS-1:0] r_link_vc;
    logic [FLIT_W-1:0]  r_link_flit;
    logic               r_credit_err;

    logic [NUM_VC-1:0]  w_eligible;
    logic [NUM_VC-1:0]  w_candidates;
    logic [NUM_VC-1:0]  w_cred_err;
    logic               w_grant_valid;
    logic [VC_BITS-1:0] w_grant_vc;
    logic [FLIT_W-1:0]  w_grant_flit;

    // Per-VC credit counter. A pop and a returned credit in the same cycle cancel.
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_cred
        logic [CRED_W-1:0] r_cred;
        logic              w_dec;
        logic              w_inc;

        assign w_dec          = w_grant_valid && (w_grant_vc == VC_BITS'(gi));
        assign w_inc          = credit_valid && (credit_vc == VC_BITS'(gi));
        assign w_cred_err[gi] = w_inc && !w_dec && (r_cred == CRED_MAX);
        assign w_eligible[gi] = !vc_empty[gi] && (r_cred != '0);

        // NOTE: sequential state is updated with non-blocking assignments only,
        // so every flop samples pre-edge values regardless of process order.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cred <= CRED_MAX;
            end else if (w_dec && !w_inc) begin
                r_cred <= r_cred - CRED_W'(1);
            end else if (w_inc && !w_dec && (r_cred != CRED_MAX)) begin
                r_cred <= r_cred + CRED_W'(1);
            end
        end
    end

`ifdef VC_LINK_TX_PKT_LOCK_EN
    logic               r_lock;
    logic [VC_BITS-1:0] r_lock_vc;
    logic [1:0]         w_grant_type;

    assign w_grant_type = w_grant_flit[FLIT_W-1 -: 2];

    always_comb begin
        w_candidates = w_eligible;
        if (r_lock) begin
            w_candidates = w_eligible & (NUM_VC'(1) << r_lock_vc);
        end
    end

    // Head (01) opens a packet lock on its VC, tail (10) closes it; 11 never locks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock    <= 1'b0;
            r_lock_vc <= '0;
        end else if (w_grant_valid) begin
            if (w_grant_type == 2'b01) begin
                r_lock    <= 1'b1;
                r_lock_vc <= w_grant_vc;
            end else if (w_grant_type == 2'b10) begin
                r_lock    <= 1'b0;
            end
        end
    end
`else
    assign w_candidates = w_eligible;
`endif

    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_VC.
    always_comb begin
        logic [VC_BITS-1:0] idx;
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        w_grant_valid = 1'b0;
        w_grant_vc    = r_rr_ptr;
        idx           = r_rr_ptr;
        for (int k = 0; k < NUM_VC; k++) begin
            idx = r_rr_ptr + VC_BITS'(k);
            if (!w_grant_valid && w_candidates[idx]) begin
                w_grant_valid = 1'b1;
                w_grant_vc    = idx;
            end
        end
    end

    assign w_grant_flit = vc_data[w_grant_vc*FLIT_W +: FLIT_W];

    always_comb begin
        vc_read_en = '0;
        if (reset_n && w_grant_valid) begin
            vc_read_en[w_grant_vc] = 1'b1;
        end
    end

    // Link stage: exactly one cycle from buffer head to link. Data/VC hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_link_valid <= 1'b0;
            r_link_vc    <= '0;
            r_link_flit  <= '0;
            r_credit_err <= 1'b0;
        end else begin
            r_link_valid <= w_grant_valid;
            r_credit_err <= |w_cred_err;
            if (w_grant_valid) begin
                r_rr_ptr    <= w_grant_vc + VC_BITS'(1);
                r_link_vc   <= w_grant_vc;
                r_link_flit <= w_grant_flit;
            end
        end
    end

    assign link_valid = r_link_valid;
    assign link_vc    = r_link_vc;
    assign link_flit  = r_link_flit;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_vc_link_tx.sv
// Directed self-checking bench for vc_link_tx with a queue model of the VC buffers.
// The packet-lock scenario runs only when VC_LINK_TX_PKT_LOCK_EN is defined.
module tb_vc_link_tx;

    localparam int VC_BITS = 2;
    localparam int FLIT_W  = 32;
    localparam int NUM_VC  = 4;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_VC-1:0]        vc_empty;
    logic [NUM_VC*FLIT_W-1:0] vc_data;
    logic [NUM_VC-1:0]        vc_read_en;
    logic                     credit_valid;
    logic [VC_BITS-1:0]       credit_vc;
    logic                     link_valid;
    logic [VC_BITS-1:0]       link_vc;
    logic [FLIT_W-1:0]        link_flit;
    logic                     credit_err;

    int checks = 0;
    int errors = 0;

    logic [FLIT_W-1:0] q [NUM_VC][$];
    logic [NUM_VC-1:0] re_q = '0;

    vc_link_tx #(
        .VC_BITS (VC_BITS),
        .FLIT_W  (FLIT_W),
        .CREDITS (32),
        .CRED_W  (6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vc_empty     (vc_empty),
        .vc_data      (vc_data),
        .vc_read_en   (vc_read_en),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .link_valid   (link_valid),
        .link_vc      (link_vc),
        .link_flit    (link_flit),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture the pop strobe just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        re_q = vc_read_en;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_VC; i++) begin
            vc_empty[i]                = (q[i].size() == 0);
            vc_data[i*FLIT_W +: FLIT_W] = (q[i].size() == 0) ? '0 : q[i][0];
        end
    endtask

    task automatic push(input int vc, input logic [FLIT_W-1:0] d);
        q[vc].push_back(d);
        refresh();
    endtask

    // Advance one clock; buffer pops follow the strobe seen at the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (re_q[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        refresh();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_flit(input string tag, input logic [VC_BITS-1:0] vc, input logic [FLIT_W-1:0] d);
        check({tag, "_valid"}, 64'(link_valid), 64'(1));
        check({tag, "_vc"},    64'(link_vc),    64'(vc));
        check({tag, "_flit"},  64'(link_flit),  64'(d));
    endtask

    initial begin
        int cnt;
        reset_n      = 1'b0;
        credit_valid = 1'b0;
        credit_vc    = '0;
        vc_data      = '0;
        vc_empty     = '1;
        refresh();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_link_valid", 64'(link_valid), 64'(0));
        check("rst_link_vc",    64'(link_vc),    64'(0));
        check("rst_link_flit",  64'(link_flit),  64'(0));
        check("rst_credit_err", 64'(credit_err), 64'(0));
        check("rst_read_en",    64'(vc_read_en), 64'(0));
        reset_n = 1'b1;
        tick();

        // VC0 and VC2 compete: strict alternation starting at VC0.
        for (int i = 0; i < 4; i++) begin
            q[0].push_back(32'h0B00 + 32'(i));
            q[2].push_back(32'h0C00 + 32'(i));
        end
        refresh();
        #1;
        check("rr_first_read_en", 64'(vc_read_en), 64'(4'b0001));
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) expect_flit("rr_vc0", 2'd0, 32'h0B00 + 32'(k / 2));
            else            expect_flit("rr_vc2", 2'd2, 32'h0C00 + 32'(k / 2));
        end
        tick();
        check("rr_idle", 64'(link_valid), 64'(0));

        // Single VC with three flits; link data and VC hold once idle.
        push(1, 32'hA1);
        push(1, 32'hA2);
        push(1, 32'hA3);
        #1;
        check("vc1_read_en0", 64'(vc_read_en), 64'(4'b0010));
        tick();
        expect_flit("vc1_a1", 2'd1, 32'hA1);
        check("vc1_read_en1", 64'(vc_read_en), 64'(4'b0010));
        tick();
        expect_flit("vc1_a2", 2'd1, 32'hA2);
        check("vc1_read_en2", 64'(vc_read_en), 64'(4'b0010));
        tick();
        expect_flit("vc1_a3", 2'd1, 32'hA3);
        check("vc1_read_en3", 64'(vc_read_en), 64'(4'b0000));
        tick();
        check("vc1_idle_valid", 64'(link_valid), 64'(0));
        check("vc1_hold_flit",  64'(link_flit),  64'(32'hA3));
        check("vc1_hold_vc",    64'(link_vc),    64'(1));

        // VC3 exhausts its 32 credits, then one returned credit releases one flit.
        for (int i = 0; i < 33; i++) q[3].push_back(32'h0D00 + 32'(i));
        refresh();
        #1;
        check("cr_read_en_first", 64'(vc_read_en), 64'(4'b1000));
        for (int i = 0; i < 32; i++) begin
            tick();
            expect_flit("cr_vc3", 2'd3, 32'h0D00 + 32'(i));
            check("cr_read_en", 64'(vc_read_en), (i < 31) ? 64'(4'b1000) : 64'(4'b0000));
        end
        tick();
        check("cr_starved_valid", 64'(link_valid), 64'(0));
        credit_valid = 1'b1;
        credit_vc    = 2'd3;
        #1;
        check("cr_ret_not_yet", 64'(vc_read_en), 64'(4'b0000));
        tick();
        credit_valid = 1'b0;
        #1;
        check("cr_ret_read_en", 64'(vc_read_en), 64'(4'b1000));
        check("cr_ret_valid0",  64'(link_valid), 64'(0));
        tick();
        expect_flit("cr_extra", 2'd3, 32'h0D20);
        check("cr_after_read_en", 64'(vc_read_en), 64'(4'b0000));
        tick();
        check("cr_after_valid", 64'(link_valid), 64'(0));

        // VC0 refilled to 32 (no error), then one more return overflows.
        credit_valid = 1'b1;
        credit_vc    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_refill", 64'(credit_err), 64'(0));
        end
        tick();
        credit_valid = 1'b0;
        check("err_pulse", 64'(credit_err), 64'(1));
        tick();
        check("err_one_cycle", 64'(credit_err), 64'(0));

        // Grant plus return on VC0 in one cycle nets to zero: 33 flits before stall.
        for (int i = 0; i < 40; i++) q[0].push_back(32'h0E00 + 32'(i));
        refresh();
        credit_valid = 1'b1;
        credit_vc    = 2'd0;
        #1;
        check("net0_read_en", 64'(vc_read_en), 64'(4'b0001));
        tick();
        credit_valid = 1'b0;
        check("net0_no_err", 64'(credit_err), 64'(0));
        expect_flit("net0_first", 2'd0, 32'h0E00);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (link_valid) cnt++;
        end
        check("net0_total_flits", 64'(cnt), 64'(33));

        // Reset while a flit is on the link.
        push(1, 32'hF0);
        push(1, 32'hF1);
        #1;
        check("rst2_read_en_pre", 64'(vc_read_en), 64'(4'b0010));
        tick();
        expect_flit("rst2_inflight", 2'd1, 32'hF0);
        reset_n = 1'b0;
        #1;
        check("rst2_valid_async", 64'(link_valid), 64'(0));
        check("rst2_flit_async",  64'(link_flit),  64'(0));
        check("rst2_vc_async",    64'(link_vc),    64'(0));
        check("rst2_read_en",     64'(vc_read_en), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rst2_ptr0_read_en", 64'(vc_read_en), 64'(4'b0001));
        tick();
        expect_flit("rst2_g0", 2'd0, 32'h0E00 + 32'(33));
        tick();
        expect_flit("rst2_g1", 2'd1, 32'hF1);
        tick();
        expect_flit("rst2_g2", 2'd0, 32'h0E00 + 32'(34));
        for (int i = 0; i < 33; i++) q[3].push_back(32'h0D80 + 32'(i));
        refresh();
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (link_valid && link_vc == 2'd3) cnt++;
        end
        check("rst2_vc3_credits", 64'(cnt), 64'(32));

`ifdef VC_LINK_TX_PKT_LOCK_EN
        // Packet lock: VC1 waits behind VC0's open packet even while the link idles.
        reset_n = 1'b0;
        for (int i = 0; i < NUM_VC; i++) q[i].delete();
        refresh();
        tick();
        reset_n = 1'b1;
        push(0, 32'h4000_00A0);
        push(0, 32'h0000_00A1);
        push(1, 32'hC000_00B0);
        tick();
        expect_flit("lock_head", 2'd0, 32'h4000_00A0);
        tick();
        expect_flit("lock_body", 2'd0, 32'h0000_00A1);
        tick();
        check("lock_idle1", 64'(link_valid), 64'(0));
        tick();
        check("lock_idle2", 64'(link_valid), 64'(0));
        push(0, 32'h8000_00A2);
        tick();
        expect_flit("lock_tail", 2'd0, 32'h8000_00A2);
        tick();
        expect_flit("lock_vc1", 2'd1, 32'hC000_00B0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
